// File: rtl/word_bus_arbiter.sv
// word_bus_arbiter: four-way round-robin arbiter for a shared 16-bit word bus.
// The grant is one-hot and registered, with a matching 2-bit select. The
// selected requester's word is driven combinationally onto o_val.
// Optional feature macro: ARB_TIMEOUT_EN forces release after TIMEOUT cycles of holding.
module word_bus_arbiter #(
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [0:3]       i_req,
    input  logic             i_done,
    input  logic [0:WIDTH-1] i_val0,
    input  logic [0:WIDTH-1] i_val1,
    input  logic [0:WIDTH-1] i_val2,
    input  logic [0:WIDTH-1] i_val3,
    output logic [0:3]       o_gnt,
    output logic [0:1]       o_sel,
    output logic [0:WIDTH-1] o_val,
    output logic             o_busy,
    output logic             o_timeout
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state;
    logic [1:0] ptr;
    logic       any_req;
    logic [1:0] pick;
    logic [0:3] pick_onehot;
    logic       release_req;
    logic       force_release;

    // This block is empty. It is elaborated only when TIMEOUT is outside 2..255.
    if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_timeout_out_of_range
    end

    // Round-robin search. The requester after the last holder is checked first.
    always_comb begin
        any_req = 1'b0;
        pick    = ptr;
        for (int i = 1; i <= 4; i++) begin
            if (!any_req && i_req[ptr + 2'(i)]) begin
                any_req = 1'b1;
                pick    = ptr + 2'(i);
            end
        end
    end

    // One-hot form of the chosen requester, ready to be loaded into o_gnt.
    always_comb begin
        pick_onehot       = '0;
        pick_onehot[pick] = 1'b1;
    end

    // The holder gives the bus back with i_done or by dropping its request.
    assign release_req = i_done || !i_req[o_sel];

`ifdef ARB_TIMEOUT_EN
    logic [7:0] hold_cnt;

    assign force_release = (hold_cnt == 8'(TIMEOUT - 1));

    // Count how long the current grant has been held. Raise o_timeout only
    // when the release is forced, not when it is voluntary.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            hold_cnt  <= '0;
            o_timeout <= 1'b0;
        end else begin
            o_timeout <= 1'b0;
            if (state == IDLE) begin
                hold_cnt <= '0;
            end else begin
                if (force_release && !release_req) begin
                    o_timeout <= 1'b1;
                end
                if (hold_cnt != 8'hFF) begin
                    hold_cnt <= hold_cnt + 8'd1;
                end
            end
        end
    end
`else
    assign force_release = 1'b0;
    assign o_timeout     = 1'b0;
`endif

    // Arbitration FSM. All grant outputs are registered here.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state  <= IDLE;
            o_gnt  <= '0;
            o_sel  <= '0;
            o_busy <= 1'b0;
            ptr    <= 2'd3;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        state  <= GRANT;
                        o_gnt  <= pick_onehot;
                        o_sel  <= pick;
                        o_busy <= 1'b1;
                    end
                end
                GRANT: begin
                    if (release_req || force_release) begin
                        state  <= IDLE;
                        o_gnt  <= '0;
                        o_busy <= 1'b0;
                        ptr    <= o_sel;
                    end
                end
                default: begin
                    state  <= IDLE;
                    o_gnt  <= '0;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

    // Word mux. When idle it still shows the word of the last holder.
    always_comb begin
        case (o_sel)
            2'd0:    o_val = i_val0;
            2'd1:    o_val = i_val1;
            2'd2:    o_val = i_val2;
            default: o_val = i_val3;
        endcase
    end

endmodule

// File: tb/tb_word_bus_arbiter.sv
// tb_word_bus_arbiter: randomized self-checking bench for word_bus_arbiter.
// The reference model tracks the holder, the last holder and the hold time as plain integers.
module tb_word_bus_arbiter;

    localparam int WIDTH   = 16;
    localparam int TIMEOUT = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [0:3]       req = '0;
    logic             done = 1'b0;
    logic [0:WIDTH-1] val0 = '0;
    logic [0:WIDTH-1] val1 = '0;
    logic [0:WIDTH-1] val2 = '0;
    logic [0:WIDTH-1] val3 = '0;
    logic [0:3]       gnt;
    logic [0:1]       sel;
    logic [0:WIDTH-1] valOut;
    logic             busy;
    logic             tout;

    int total = 0;
    int bad   = 0;

    int mHolder;
    int mPtr;
    int mSel;
    int mCnt;
    bit mTout;

`ifdef ARB_TIMEOUT_EN
    bit toEn = 1'b1;
`else
    bit toEn = 1'b0;
`endif

    // Free-running clock with a 10 ns period.
    always #5 clk = ~clk;

    word_bus_arbiter #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_req    (req),
        .i_done   (done),
        .i_val0   (val0),
        .i_val1   (val1),
        .i_val2   (val2),
        .i_val3   (val3),
        .o_gnt    (gnt),
        .o_sel    (sel),
        .o_val    (valOut),
        .o_busy   (busy),
        .o_timeout(tout)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic modelReset();
        mHolder = -1;
        mPtr    = 3;
        mSel    = 0;
        mCnt    = 0;
        mTout   = 1'b0;
    endtask

    // One clock edge of the model. It uses the inputs present at that edge.
    task automatic modelStep();
        int  k;
        bit  rel;
        bit  to;
        mTout = 1'b0;
        if (mHolder < 0) begin
            for (int j = 1; j <= 4; j++) begin
                k = (mPtr + j) % 4;
                if (req[k]) begin
                    mHolder = k;
                    mSel    = k;
                    mCnt    = 0;
                    break;
                end
            end
        end else begin
            rel = done || !req[mHolder];
            to  = toEn && (mCnt == TIMEOUT - 1);
            if (rel || to) begin
                mPtr    = mHolder;
                mHolder = -1;
                mTout   = to && !rel;
            end else if (mCnt < 255) begin
                mCnt++;
            end
        end
    endtask

    function automatic logic [0:WIDTH-1] expWord(input int s);
        case (s)
            0:       return val0;
            1:       return val1;
            2:       return val2;
            default: return val3;
        endcase
    endfunction

    task automatic checkAll();
        logic [0:3] eg;
        eg = '0;
        if (mHolder >= 0) eg[mHolder] = 1'b1;
        checkOutput("gnt", gnt, eg);
        checkOutput("sel", sel, mSel);
        checkOutput("busy", busy, (mHolder >= 0));
        checkOutput("timeout", tout, mTout);
        checkOutput("val", valOut, expWord(mSel));
    endtask

    task automatic applyStimulus(input logic [0:3] r, input logic d);
        req  = r;
        done = d;
        val0 = WIDTH'($urandom);
        val1 = WIDTH'($urandom);
        val2 = WIDTH'($urandom);
        val3 = WIDTH'($urandom);
    endtask

    task automatic tick();
        @(posedge clk);
        modelStep();
        #1;
        checkAll();
    endtask

    // Asserts reset between clock edges. The grant must clear at once.
    task automatic pulseReset();
        rst_n = 1'b0;
        #1;
        modelReset();
        checkAll();
        checkOutput("rstGnt", gnt, 4'b0000);
        checkOutput("rstSel", sel, 2'b00);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int guard;
        applyStimulus(4'b0000, 1'b0);
        rst_n = 1'b0;
        #12;
        modelReset();
        checkAll();
        rst_n = 1'b1;

        // Basic grant and release, with the last holder's word kept on o_val.
        applyStimulus(4'b1000, 1'b0);
        val0 = 16'hA5A5;
        tick();
        checkOutput("dirGnt0", gnt, 4'b1000);
        checkOutput("dirVal0", valOut, 16'hA5A5);
        applyStimulus(4'b1000, 1'b1);
        val0 = 16'hA5A5;
        tick();
        checkOutput("dirRelease", gnt, 4'b0000);
        checkOutput("dirValHold", valOut, 16'hA5A5);
        applyStimulus(4'b0000, 1'b0);
        tick();

        // Fairness: all four request, and every grant is released at once.
        for (int i = 0; i < 12; i++) begin
            applyStimulus(4'b1111, 1'b1);
            tick();
        end

        // A holder that drops its request, followed by all four requesting.
        applyStimulus(4'b0000, 1'b0);
        tick();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(4'b0010, 1'b0);
            tick();
        end
        applyStimulus(4'b0000, 1'b0);
        tick();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(4'b1111, 1'b0);
            tick();
        end

        // Reset while requester 1 holds the bus, then a 0110 request.
        applyStimulus(4'b0000, 1'b0);
        tick();
        applyStimulus(4'b0100, 1'b0);
        guard = 0;
        while (mHolder != 1 && guard < 10) begin
            tick();
            guard++;
        end
        checkOutput("holdBeforeReset", gnt, 4'b0100);
        pulseReset();
        applyStimulus(4'b0110, 1'b0);
        tick();
        checkOutput("afterResetGnt", gnt, 4'b0100);

        // Long hold with no i_done: timeout pulses or an indefinite hold.
        applyStimulus(4'b0000, 1'b0);
        tick();
        for (int i = 0; i < 300; i++) begin
            applyStimulus(4'b1100, 1'b0);
            tick();
        end

        // Random traffic with occasional asynchronous resets.
        for (int i = 0; i < 2000; i++) begin
            applyStimulus(4'($urandom), ($urandom_range(0, 3) == 0));
            tick();
            if ($urandom_range(0, 199) == 0) pulseReset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
